// File: rtl/instr_encoder_if.sv
// Field-side and instruction-side handshake bundle for instr_encoder.
// The master drives requests and consumes encoded words; the slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [5:0]  in_op;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_opcode, in_op, in_rs1, in_rs2, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_opcode, in_op, in_rs1, in_rs2, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns decoded fields back into a 32-bit word,
// rejects illegal/unencodable requests, and queues legal words in a FIFO.
module instr_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  instr_encoder_if.slave          bus,
  output logic                    err,
  output logic [7:0]              err_count,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LOAD   = 7'b0000011,
    OPC_IMM    = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

  opcode_e     opc;
  fmt_e        fmt;
  logic [2:0]  f3;
  logic        alt;
  logic [31:0] imm;
  logic        f3_ok;
  logic        alt_ok;
  logic        imm_ok;
  logic        reject;
  logic [31:0] word;

  logic          accept;
  logic          push;
  logic          pop;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   mem [DEPTH];

  assign opc = opcode_e'(bus.in_opcode);
  assign f3  = bus.in_op[2:0];
  assign alt = bus.in_op[3];
  assign imm = bus.in_imm;

  // Map the major opcode to its instruction format; shifts get their own format.
  always_comb begin
    fmt = FMT_X;
    case (opc)
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_JALR, OPC_LOAD: fmt = FMT_I;
      OPC_IMM:            fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_REG:            fmt = FMT_R;
      default:            fmt = FMT_X;
    endcase
  end

  // Legality: funct3 per opcode, funct7[5] usage, and immediate encodability.
  always_comb begin
    f3_ok = 1'b1;
    case (opc)
      OPC_JALR:   f3_ok = (f3 == 3'b000);
      OPC_BRANCH: f3_ok = !(f3 == 3'b010 || f3 == 3'b011);
      OPC_LOAD:   f3_ok = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      OPC_STORE:  f3_ok = (f3 <= 3'b010);
      default:    f3_ok = 1'b1;
    endcase

    alt_ok = !alt
          || (opc == OPC_REG && (f3 == 3'b000 || f3 == 3'b101))
          || (opc == OPC_IMM && f3 == 3'b101);

    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: imm_ok = (&imm[31:11]) || !(|imm[31:11]);
      FMT_B:        imm_ok = !imm[0] && ((&imm[31:12]) || !(|imm[31:12]));
      FMT_J:        imm_ok = !imm[0] && ((&imm[31:20]) || !(|imm[31:20]));
      FMT_U:        imm_ok = (imm[11:0] == '0);
      FMT_SH:       imm_ok = (imm[31:5] == '0);
      default:      imm_ok = 1'b1;
    endcase

    reject = (fmt == FMT_X) || (bus.in_op[5:4] != 2'b00) || !f3_ok || !alt_ok || !imm_ok;
  end

  // Scatter the fields into the instruction word according to the format.
  always_comb begin
    word = '0;
    case (fmt)
      FMT_U:  word = {imm[31:12], bus.in_rd, bus.in_opcode};
      FMT_J:  word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
      FMT_I:  word = {imm[11:0], bus.in_rs1, f3, bus.in_rd, bus.in_opcode};
      FMT_SH: word = {1'b0, alt, 5'b0, imm[4:0], bus.in_rs1, f3, bus.in_rd, bus.in_opcode};
      FMT_S:  word = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], bus.in_opcode};
      FMT_B:  word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3,
                      imm[4:1], imm[11], bus.in_opcode};
      FMT_R:  word = {1'b0, alt, 5'b0, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, bus.in_opcode};
      default: word = '0;
    endcase
  end

  // A rejected request is still consumed; only legal words enter the FIFO.
  assign bus.in_ready  = (level < FULL) && !flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && !reject;
  assign pop           = bus.out_valid && bus.out_ready && !flush;
  assign bus.out_valid = (level != '0);
  assign bus.out_instr = mem[rptr];

  // FIFO pointers and occupancy; flush empties the queue and overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= word;
  end

  // Rejection pulse and saturating rejection counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= accept && reject;
      if (accept && reject && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expected words.
module tb_instr_encoder;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       err;
  logic [7:0] err_count;
  logic [2:0] level;

  instr_encoder_if bus ();

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .err       (err),
    .err_count (err_count),
    .level     (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] q[$];
  logic [31:0] got[$];
  int unsigned exp_cnt = 0;
  bit          exp_err = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference encoder built from the ISA field placement, using arithmetic on the immediate.
  function automatic bit model(input logic [6:0] opc, input logic [5:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm,
                               output logic [31:0] w);
    logic [2:0]  f3;
    logic [31:0] fo, frd, fr1, fr2, ff3, f7;
    int          s;
    bit          ok;
    f3  = op[2:0];
    s   = $signed(imm);
    fo  = 32'(opc);
    frd = 32'(rd) << 7;
    fr1 = 32'(rs1) << 15;
    fr2 = 32'(rs2) << 20;
    ff3 = 32'(f3) << 12;
    f7  = op[3] ? 32'h4000_0000 : 32'h0;
    ok  = (op[5:4] == 2'b00);
    ok  = ok && (!op[3] || (opc == 7'h33 && (f3 == 0 || f3 == 5)) || (opc == 7'h13 && f3 == 5));
    w   = 32'h0;
    case (opc)
      7'h37, 7'h17: begin
        ok = ok && ((imm & 32'hFFF) == 0);
        w  = fo | frd | (imm & 32'hFFFF_F000);
      end
      7'h6F: begin
        ok = ok && s >= -(1 << 20) && s < (1 << 20) && (imm % 2 == 0);
        w  = fo | frd | (imm & 32'h000F_F000) | (((imm >> 11) & 1) << 20)
           | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
      end
      7'h67, 7'h03: begin
        if (opc == 7'h67) ok = ok && f3 == 0;
        else              ok = ok && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        ok = ok && s >= -2048 && s < 2048;
        w  = fo | frd | ff3 | fr1 | (imm << 20);
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          ok = ok && imm < 32;
          w  = fo | frd | ff3 | fr1 | (imm << 20) | f7;
        end else begin
          ok = ok && s >= -2048 && s < 2048;
          w  = fo | frd | ff3 | fr1 | (imm << 20);
        end
      end
      7'h23: begin
        ok = ok && f3 <= 2 && s >= -2048 && s < 2048;
        w  = fo | ff3 | fr1 | fr2 | ((imm & 31) << 7) | (((imm >> 5) & 127) << 25);
      end
      7'h63: begin
        ok = ok && f3 != 2 && f3 != 3 && s >= -4096 && s < 4096 && (imm % 2 == 0);
        w  = fo | ff3 | fr1 | fr2 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8)
           | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      end
      7'h33: w = fo | frd | ff3 | fr1 | fr2 | f7;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Reference state: queue of accepted words, error pulse and saturating count.
  initial begin
    bit          rdy, acc, ok;
    logic [31:0] w;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
      end else begin
        rdy = (q.size() < DEPTH) && !flush;
        acc = bus.in_valid && rdy;
        ok  = model(bus.in_opcode, bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_imm, w);
        if (flush) q.delete();
        else begin
          if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
          if (acc && ok) q.push_back(w);
        end
        exp_err = acc && !ok;
        if (exp_err && exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // Per-cycle comparison against the reference, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("level", 32'(level), 32'(q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) && !flush));
      chk("err", 32'(err), 32'(exp_err));
      chk("err_count", 32'(err_count), exp_cnt);
      if (q.size() != 0) chk("out_instr", bus.out_instr, q[0]);
    end
  end

  // Record every word the sink takes.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready && !flush && !rst) got.push_back(bus.out_instr);
    end
  end

  task automatic drive(input logic [6:0] opc, input logic [5:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
    bus.in_opcode = opc;
    bus.in_op     = op;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.in_imm    = imm;
  endtask

  task automatic wait_accept();
    bit r;
    int n = 0;
    forever begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        break;
      end
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [6:0] opc, input logic [5:0] op, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
    @(posedge clk);
    #1;
    drive(opc, op, rs1, rs2, rd, imm);
    bus.in_valid = 1'b1;
    wait_accept();
  endtask

  initial begin
    logic [31:0] w;
    bit          ok;
    int          n;

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(7'h0, 6'h0, 5'd0, 5'd0, 5'd0, 32'h0);

    // Reference model pinned against hand-encoded words.
    ok = model(7'h13, 6'b000000, 5'd0, 5'd0, 5'd1, 32'd5, w);
    chk("model_addi", w, 32'h0050_0093);
    ok = model(7'h33, 6'b001000, 5'd1, 5'd2, 5'd3, 32'd0, w);
    chk("model_sub", w, 32'h4020_81B3);
    ok = model(7'h37, 6'b000000, 5'd0, 5'd0, 5'd5, 32'h1234_5000, w);
    chk("model_lui", w, 32'h1234_52B7);
    ok = model(7'h63, 6'b000000, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, w);
    chk("model_beq", w, 32'hFE20_8EE3);
    chk("model_beq_ok", 32'(ok), 32'd1);
    ok = model(7'h63, 6'b000000, 5'd1, 5'd2, 5'd0, 32'd3, w);
    chk("model_beq_odd_ok", 32'(ok), 32'd0);
    ok = model(7'h03, 6'b000011, 5'd1, 5'd0, 5'd2, 32'd0, w);
    chk("model_ld011_ok", 32'(ok), 32'd0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADDI with one-cycle latency, then SUB and LUI, drained in order.
    send(7'h13, 6'b000000, 5'd0, 5'd0, 5'd1, 32'd5);
    @(negedge clk);
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_word", bus.out_instr, 32'h0050_0093);
    send(7'h33, 6'b001000, 5'd1, 5'd2, 5'd3, 32'd0);
    send(7'h37, 6'b000000, 5'd0, 5'd0, 5'd5, 32'h1234_5000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain0", bus.out_instr, 32'h0050_0093);
    @(negedge clk);
    chk("drain1", bus.out_instr, 32'h4020_81B3);
    @(negedge clk);
    chk("drain2", bus.out_instr, 32'h1234_52B7);
    @(negedge clk);
    chk("drain_empty", 32'(level), 32'd0);

    // BEQ legal, then the odd-offset variant is rejected.
    send(7'h63, 6'b000000, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("beq_word", bus.out_instr, 32'hFE20_8EE3);
    send(7'h63, 6'b000000, 5'd1, 5'd2, 5'd0, 32'd3);
    @(negedge clk);
    chk("beq_odd_err", 32'(err), 32'd1);
    chk("beq_odd_count", 32'(err_count), 32'd1);
    chk("beq_odd_level", 32'(level), 32'd0);

    // LOAD with funct3 011 is rejected.
    send(7'h03, 6'b000011, 5'd1, 5'd0, 5'd2, 32'd0);
    @(negedge clk);
    chk("ld011_err", 32'(err), 32'd1);
    chk("ld011_count", 32'(err_count), 32'd2);
    chk("ld011_level", 32'(level), 32'd0);

    // Fill to DEPTH, hold a fifth, then drain with a simultaneous push/pop.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) send(7'h13, 6'b000000, 5'd0, 5'd0, 5'd1, 32'(16 + i));
    @(posedge clk);
    #1;
    drive(7'h13, 6'b000000, 5'd0, 5'd0, 5'd1, 32'd20);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_accept();
    n = 0;
    while (level != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fill_count", 32'(got.size()), 32'd5);
    if (got.size() == 5)
      for (int i = 0; i < 5; i++) chk("fill_order", got[i], 32'h0100_0093 + (32'(i) << 20));

    // Flush with three queued and a concurrent push and pop request.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(7'h13, 6'b000000, 5'd0, 5'd0, 5'd2, 32'(i));
    got.delete();
    @(posedge clk);
    #1;
    drive(7'h13, 6'b000000, 5'd0, 5'd0, 5'd3, 32'd9);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk("flush_level_before", 32'(level), 32'd3);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_nothing_out", 32'(got.size()), 32'd0);

    // An illegal request during flush is not counted.
    @(posedge clk);
    #1;
    drive(7'h03, 6'b000011, 5'd1, 5'd0, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_rej_err", 32'(err), 32'd0);
    chk("flush_rej_count", 32'(err_count), 32'd2);

    // 300 back-to-back rejects saturate the counter; err keeps pulsing.
    @(posedge clk);
    #1;
    drive(7'h03, 6'b000011, 5'd1, 5'd0, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("sat_err", 32'(err), 32'd1);
    chk("sat_count", 32'(err_count), 32'd255);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    send(7'h13, 6'b000000, 5'd0, 5'd0, 5'd4, 32'd1);
    send(7'h13, 6'b000000, 5'd0, 5'd0, 5'd4, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_level_after", 32'(level), 32'd0);
    got.delete();
    bus.out_ready = 1'b1;
    send(7'h6F, 6'b000000, 5'd0, 5'd0, 5'd1, 32'd8);
    repeat (3) @(negedge clk);
    chk("jal_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("jal_word", got[0], 32'h0080_00EF);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, in, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port flush, in, 1, synchronous clear of the FIFO contents.
REQ-005 SHALL have ports in_valid (in, 1) and in_ready (out, 1), the field-side handshake.
REQ-006 SHALL have port in_opcode, in, 7, the RV32I major opcode.
REQ-007 SHALL have port in_op, in, 6: op[2:0]=funct3, op[3]=funct7[5] (SUB/SRA/SRAI), op[5:4] reserved and must be 00.
REQ-008 SHALL have ports in_rs1, in_rs2 and in_rd (in, 5 each), the register indices.
REQ-009 SHALL have port in_imm, in, 32, the sign-extended immediate in decoded form.
REQ-010 SHALL have ports out_valid (out, 1), out_ready (in, 1) and out_instr (out, 32), the instruction-side handshake.
REQ-011 SHALL have port err, out, 1, a one-cycle pulse for each rejected request.
REQ-012 SHALL have port err_count, out, 8, a saturating count of rejected requests.
REQ-013 SHALL have port level, out, $clog2(DEPTH)+1, the current FIFO occupancy.

Function
REQ-014 SHALL accept a request on a rising edge with in_valid&&in_ready, where in_ready = (level<DEPTH) && !flush, with no dependence on out_ready.
REQ-015 SHALL encode the accepted fields combinationally as the inverse of the ID stage decode, then push the word into the FIFO on the same edge.
REQ-016 SHALL encode opcodes as follows:
- LUI/AUIPC: U-type.
- JAL: J-type.
- JALR/LOAD/IMM_OP: I-type.
- STORE: S-type.
- BRANCH: B-type.
- REG_OP: R-type.
REQ-017 SHALL place register fields per format: rs1 in [19:15] except U/J, rs2 in [24:20] for B/S/R, rd in [11:7] except B/S; a field that its format does not use is ignored.
REQ-018 SHALL encode IMM_OP with funct3 001/101 as [31:25]={1'b0,op[3],5'b0} and [24:20]=imm[4:0].
REQ-019 SHALL encode REG_OP as funct7 = {1'b0,op[3],5'b0}.
REQ-020 SHALL reject a request (no push, err=1 on the next cycle, err_count+1) if any of the following holds:
- unknown opcode, or op[5:4]!=0.
- JALR with funct3!=0.
- BRANCH with funct3 010/011.
- LOAD with funct3 011/110/111.
- STORE with funct3>010.
- op[3]=1 except for REG_OP funct3 000/101 or IMM_OP funct3 101.
- imm not representable: I/S not sign-extended from bit 11; B odd or not sign-extended from bit 12; J odd or not sign-extended from bit 20; U imm[11:0]!=0; shift imm[31:5]!=0.
REQ-021 SHALL consume a rejected request through the handshake (in_ready is still honoured), so it is never retried.
REQ-022 SHALL hold err_count at 255 once reached; err SHALL still pulse.
REQ-023 SHALL present the FIFO head on out_instr with out_valid = (level!=0), and pop on out_valid&&out_ready.
REQ-024 SHALL have latency accept-edge -> out_valid high = 1 cycle when the FIFO is empty; there is no bypass.
REQ-025 SHALL deliver words in acceptance order; pointers wrap modulo DEPTH.
REQ-026 SHALL handle simultaneous push and pop: level unchanged, both take effect.
REQ-027 SHALL handle a pop when empty and a push when full as no-ops.
REQ-028 SHALL keep out_instr stable while out_valid&&!out_ready.
REQ-029 SHALL, on flush, set level=0 on the next edge, discard any simultaneous push/pop, and leave err_count unchanged; a rejection in the same cycle SHALL NOT be counted.

Reset
REQ-030 SHALL, when rst is asserted, immediately clear level, the pointers, err and err_count, and drive out_valid=0; out_instr is a don't-care while out_valid=0.
REQ-031 SHALL discard FIFO contents when rst is asserted mid-operation, and set in_ready=1 on the first edge after rst deasserts.

Verification
REQ-032 SHALL cover ADDI: opcode 0010011, op 0, rs1 0, rd 1, imm 5 -> out_instr 0x00500093, out_valid one cycle after accept.
REQ-033 SHALL cover SUB and LUI:
- SUB: op 001000, rs1 1, rs2 2, rd 3 -> 0x402081B3.
- LUI: rd 5, imm 0x12345000 -> 0x123452B7.
REQ-034 SHALL cover BEQ: rs1 1, rs2 2, imm 0xFFFFFFFC -> 0xFE208EE3; the same request with imm 3 -> err pulse, err_count 1, no output.
REQ-035 SHALL cover fill and drain: out_ready=0, push 5 -> in_ready low after 4 (level 4), fifth held; out_ready=1 -> 4 words in order, then the fifth.
REQ-036 SHALL cover rejects: LOAD funct3 011 -> err, no push; 300 rejects -> err_count 255.
REQ-037 SHALL cover reset and flush: flush with level 3 and a concurrent push -> level 0, nothing out; rst asserted mid-stream -> level 0 and out_valid 0 immediately.
